pintor_pixel: RTL and testbench
===============================

# pintor_pixel

Per-pixel colour generator sitting directly downstream of the VGA timing/screen block (`tela`). It consumes the raw VGA beam coordinates and active flag, plus the positions of the ship, enemy and both projectiles. It produces the 3-bit-per-channel colour (`R_AUX`/`G_AUX`/`B_AUX`) that the top level expands to 8-bit VGA. Object positions are latched once per frame, and hit tests run in a 3-stage pipeline.

## Interface
Parameters:
- `H_OFFSET`, 144, horizontal counter value of first visible pixel
- `V_OFFSET`, 35, vertical counter value of first visible line
- `BLINK_BIT`, 5, frame-counter bit that drives the game-over blink

Ports:
- `CLOCK_50`  in  1  system clock; one clock for the whole block
- `reset`  in  1  asynchronous, active-high reset
- `xVGA`, `yVGA`  in  10  raw beam counters from `tela`
- `ativoVGA`  in  1  beam is in the visible area
- `perdeu`  in  1  game-over flag
- `BordaNaveX`, `BordaNaveY`, `LarguraNave`, `AlturaNave`  in  10 each  ship rectangle: top-left corner, width, height
- `BordaInimigoX`, `BordaInimigoY`, `LarguraInimigo`, `AlturaInimigo`  in  10 each  enemy rectangle
- `BolaNaveX`, `BolaNaveY`, `RaioBolaNave`  in  10 each  ship projectile: centre and radius
- `BolaInimigoX`, `BolaInimigoY`, `RaioBolaInimigo`  in  10 each  enemy projectile
- `R_AUX`, `G_AUX`, `B_AUX`  out  3 each  pixel colour
- `ativo_out`  out  1  `ativoVGA` delayed to match the colour outputs

## Operation
- **Shadow registers.** All 14 object inputs are copied into shadow registers on the cycle where `xVGA==0 && yVGA==0` (frame start). Input changes at any other time have no visible effect until the next frame start.
- **Frame counter.** A 6-bit frame counter increments at each frame start and wraps from 63 to 0.
- **Stage 1.**
  - Screen coordinates: `xs = xVGA - H_OFFSET`, `ys = yVGA - V_OFFSET`, both 11-bit signed.
  - Rectangle hit, per rectangle: `xs >= X && xs < X+W && ys >= Y && ys < Y+H`. Sums are 11-bit, so there is no wrap.
  - Circle deltas: `dx = xs - cx`, `dy = ys - cy`, 11-bit signed.
- **Stage 2.** Compute `dx²` and `dy²` (21-bit unsigned) and `r²` (20-bit).
- **Stage 3.**
  - Circle hit when `dx²+dy² <= r²` (22-bit sum).
  - Priority mux, first hit wins:
    - ship projectile: white 7/7/7
    - enemy projectile: yellow 7/7/0
    - ship: green 0/7/0
    - enemy: red 7/0/0
    - background: black 0/0/0
  - If `perdeu && frame_counter[BLINK_BIT]`, the background becomes 4/0/0. Objects still draw on top of it.
- **Zero sizes.** A width, height or radius of 0 means the object is not drawn; in particular, radius 0 draws nothing, not a single pixel.
- **Inactive pixels.** When the delayed `ativo` is 0, the outputs are 0/0/0 regardless of hits.
- **Coordinates outside 0..639 / 0..479** are never active, so they need no special handling.

## Timing
- Latency is exactly 3 `CLOCK_50` cycles from `xVGA`/`yVGA`/`ativoVGA` to `R_AUX`/`G_AUX`/`B_AUX`/`ativo_out`.
- The pipeline is fully pipelined and accepts one new coordinate every cycle; there is no stall or handshake.
- The shadow-register update takes effect for pixels sampled from the cycle after frame start. The frame-start pixel itself uses the old values.
- Reset, asserted at any time (including mid-frame):
  - every output is 0 immediately and asynchronously;
  - all pipeline, shadow and counter registers are cleared to 0.
- After reset release, the outputs stay 0 until valid `ativoVGA` data has propagated through the 3 stages.
- Simultaneous frame start and `perdeu` change: the blink phase uses the counter value after the increment.

## Configuration
- `PINTOR_BORDA_EN` defined: pixels with `xs==0`, `xs==639`, `ys==0` or `ys==479` draw grey 3/3/3. The border sits above the background and below all objects.
- `PINTOR_BORDA_EN` not defined: no border logic is generated and the border pixels follow the normal rules.

## Structure
- Package `pintor_pkg` holds:
  - `H_ACT=640`, `V_ACT=480`
  - the colour constants
  - the 3-bit RGB struct typedef
  - the priority enum
- Sub-module `circulo_hit` covers stages 1–3 of the squared-distance compare and is instantiated twice, once per projectile.
- Rectangle tests, shadow registers, frame counter and the priority mux are in the top module.

## Test plan
- **Reset.** Assert `reset` mid-frame with white being output → RGB=0/0/0 and `ativo_out=0` in the same cycle; all registers read 0 after release.
- **Ship projectile.** Projectile at (320,240) with r=10, latched; drive `xVGA=464`, `yVGA=275`, active → 7/7/7 exactly 3 cycles later. Pixel (330,240) → white; pixel (328,247) (sum 113 > 100) → black.
- **Priority.** Ship rect (300,230,50,20) overlapping the ship projectile at (320,240) → white at (320,240); green at (345,245).
- **Latch point.** Change `BolaNaveX` from 320 to 100 mid-frame → drawing stays at 320 for the rest of the frame and moves to 100 only after `xVGA=0,yVGA=0`.
- **Game-over blink.** `perdeu=1`, background pixel → 0/0/0 for frames 0–31 and 4/0/0 for frames 32–63; counter wraps to 0 at frame 64 and the pixel is black again.
- **Border and zero sizes.**
  - With `PINTOR_BORDA_EN`: pixel (0,100) → 3/3/3.
  - Without it: pixel (0,100) → 0/0/0.
  - Radius 0 at the pixel's own coordinates → not drawn.

Source files
------------

// File: rtl/pintor_pkg.sv
// pintor_pkg: shared types, constants and helper functions for pintor_pixel.
//   H_ACT/V_ACT  : visible screen size
//   rgb_t        : 3-bit-per-channel colour
//   COR_*        : colour constants
//   prio_e       : draw priority (first hit wins)
//   objetos_t    : shadow copy of all object positions/sizes
package pintor_pkg;

    localparam int unsigned H_ACT = 640;
    localparam int unsigned V_ACT = 480;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

    localparam rgb_t COR_PRETO    = '{r: 3'd0, g: 3'd0, b: 3'd0};
    localparam rgb_t COR_BRANCO   = '{r: 3'd7, g: 3'd7, b: 3'd7};
    localparam rgb_t COR_AMARELO  = '{r: 3'd7, g: 3'd7, b: 3'd0};
    localparam rgb_t COR_VERDE    = '{r: 3'd0, g: 3'd7, b: 3'd0};
    localparam rgb_t COR_VERMELHO = '{r: 3'd7, g: 3'd0, b: 3'd0};
    localparam rgb_t COR_CINZA    = '{r: 3'd3, g: 3'd3, b: 3'd3};
    localparam rgb_t COR_PERDEU   = '{r: 3'd4, g: 3'd0, b: 3'd0};

    typedef enum logic [2:0] {
        PrioBolaNave,
        PrioBolaInimigo,
        PrioNave,
        PrioInimigo,
        PrioBorda,
        PrioFundo
    } prio_e;

    typedef struct packed {
        logic [9:0] nave_x;
        logic [9:0] nave_y;
        logic [9:0] nave_w;
        logic [9:0] nave_h;
        logic [9:0] ini_x;
        logic [9:0] ini_y;
        logic [9:0] ini_w;
        logic [9:0] ini_h;
        logic [9:0] bn_x;
        logic [9:0] bn_y;
        logic [9:0] bn_r;
        logic [9:0] bi_x;
        logic [9:0] bi_y;
        logic [9:0] bi_r;
    } objetos_t;

    // Compared in 12-bit signed so X+W (up to 2046) never wraps against a negative xs.
    function automatic logic rect_hit(input logic signed [10:0] xs, input logic signed [10:0] ys,
                                      input logic [9:0] x, input logic [9:0] y,
                                      input logic [9:0] w, input logic [9:0] h);
        logic signed [11:0] xe, ye, x0, x1, y0, y1;
        xe = {xs[10], xs};
        ye = {ys[10], ys};
        x0 = {2'b00, x};
        y0 = {2'b00, y};
        x1 = {1'b0, {1'b0, x} + {1'b0, w}};
        y1 = {1'b0, {1'b0, y} + {1'b0, h}};
        return (xe >= x0) && (xe < x1) && (ye >= y0) && (ye < y1);
    endfunction

    function automatic logic is_borda(input logic signed [10:0] xs, input logic signed [10:0] ys);
        return (xs == 11'sd0) || (xs == $signed(11'(H_ACT - 1))) ||
               (ys == 11'sd0) || (ys == $signed(11'(V_ACT - 1)));
    endfunction

    function automatic rgb_t prio_color(input prio_e prio, input logic blink);
        rgb_t c;
        case (prio)
            PrioBolaNave:    c = COR_BRANCO;
            PrioBolaInimigo: c = COR_AMARELO;
            PrioNave:        c = COR_VERDE;
            PrioInimigo:     c = COR_VERMELHO;
            PrioBorda:       c = COR_CINZA;
            default:         c = blink ? COR_PERDEU : COR_PRETO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/circulo_hit.sv
// circulo_hit: squared-distance circle hit test, stages 1-3.
//   clk, rst : clock, async active-high reset
//   xs, ys   : screen coordinates (stage 0, combinational from the top)
//   cx, cy, r: circle centre and radius (shadow registers)
//   hit      : combinational result aligned with stage 3
module circulo_hit import pintor_pkg::*; (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [10:0] xs,
    input  logic signed [10:0] ys,
    input  logic [9:0]         cx,
    input  logic [9:0]         cy,
    input  logic [9:0]         r,
    output logic               hit
);

    logic signed [10:0] dx_d, dy_d, dx_q, dy_q;
    logic [9:0]         r_q;
    logic [10:0]        adx, ady;
    logic [20:0]        adx_w, ady_w, dx_sq_d, dy_sq_d, dx_sq_q, dy_sq_q;
    logic [19:0]        r_w, r_sq_d, r_sq_q;
    logic [21:0]        dist_sq;

    // Stage 1: deltas
    assign dx_d = xs - $signed({1'b0, cx});
    assign dy_d = ys - $signed({1'b0, cy});

    // Stage 2: squares via magnitude (|-1024| = 1024 still fits 11 bits unsigned)
    always_comb begin
        adx     = dx_q[10] ? (~dx_q + 11'd1) : dx_q;
        ady     = dy_q[10] ? (~dy_q + 11'd1) : dy_q;
        adx_w   = {10'd0, adx};
        ady_w   = {10'd0, ady};
        dx_sq_d = adx_w * adx_w;
        dy_sq_d = ady_w * ady_w;
        r_w     = {10'd0, r_q};
        r_sq_d  = r_w * r_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q    <= '0;
            dy_q    <= '0;
            r_q     <= '0;
            dx_sq_q <= '0;
            dy_sq_q <= '0;
            r_sq_q  <= '0;
        end else begin
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            r_q     <= r;
            dx_sq_q <= dx_sq_d;
            dy_sq_q <= dy_sq_d;
            r_sq_q  <= r_sq_d;
        end
    end

    // Stage 3: compare; r==0 must draw nothing, not the centre pixel
    assign dist_sq = {1'b0, dx_sq_q} + {1'b0, dy_sq_q};
    assign hit     = (r_sq_q != 20'd0) && (dist_sq <= {2'b00, r_sq_q});

endmodule

// File: rtl/pintor_pixel.sv
// pintor_pixel: per-pixel colour generator, 3-cycle pipeline.
//   CLOCK_50, reset            : clock, async active-high reset
//   xVGA, yVGA, ativoVGA       : raw beam counters and visible flag
//   perdeu                     : game-over (blinks the background)
//   Borda*/Largura*/Altura*    : ship and enemy rectangles
//   Bola*/Raio*                : projectile centres and radii
//   R_AUX, G_AUX, B_AUX        : 3-bit colour, 3 cycles after the coordinate
//   ativo_out                  : ativoVGA delayed to match
// Object inputs are latched once per frame at xVGA==0 && yVGA==0.
// Define PINTOR_BORDA_EN to draw a grey 1-pixel screen border.
module pintor_pixel import pintor_pkg::*; #(
    parameter int unsigned H_OFFSET  = 144,
    parameter int unsigned V_OFFSET  = 35,
    parameter int unsigned BLINK_BIT = 5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] xVGA,
    input  logic [9:0] yVGA,
    input  logic       ativoVGA,
    input  logic       perdeu,
    input  logic [9:0] BordaNaveX,
    input  logic [9:0] BordaNaveY,
    input  logic [9:0] LarguraNave,
    input  logic [9:0] AlturaNave,
    input  logic [9:0] BordaInimigoX,
    input  logic [9:0] BordaInimigoY,
    input  logic [9:0] LarguraInimigo,
    input  logic [9:0] AlturaInimigo,
    input  logic [9:0] BolaNaveX,
    input  logic [9:0] BolaNaveY,
    input  logic [9:0] RaioBolaNave,
    input  logic [9:0] BolaInimigoX,
    input  logic [9:0] BolaInimigoY,
    input  logic [9:0] RaioBolaInimigo,
    output logic [2:0] R_AUX,
    output logic [2:0] G_AUX,
    output logic [2:0] B_AUX,
    output logic       ativo_out
);

    objetos_t           obj_d, obj_q;
    logic               frame_start;
    logic [5:0]         frame_cnt_d, frame_cnt_q;
    logic signed [10:0] xs, ys;
    logic               act_s1, nave_s1, ini_s1, blink_s1;
    logic               act_s2, nave_s2, ini_s2, blink_s2;
    logic               bn_hit, bi_hit;
    prio_e              prio;
    rgb_t               rgb_d, rgb_q;
    logic               ativo_q;

    assign frame_start = (xVGA == 10'd0) && (yVGA == 10'd0);
    assign frame_cnt_d = frame_start ? frame_cnt_q + 6'd1 : frame_cnt_q;

    assign obj_d = '{nave_x: BordaNaveX,    nave_y: BordaNaveY,
                     nave_w: LarguraNave,   nave_h: AlturaNave,
                     ini_x:  BordaInimigoX, ini_y:  BordaInimigoY,
                     ini_w:  LarguraInimigo, ini_h: AlturaInimigo,
                     bn_x:   BolaNaveX,     bn_y:   BolaNaveY,    bn_r: RaioBolaNave,
                     bi_x:   BolaInimigoX,  bi_y:   BolaInimigoY, bi_r: RaioBolaInimigo};

    assign xs = $signed({1'b0, xVGA}) - $signed(11'(H_OFFSET));
    assign ys = $signed({1'b0, yVGA}) - $signed(11'(V_OFFSET));

    // The frame-start pixel itself still sees the old shadow values, since
    // stage 1 samples obj_q on the same edge that reloads it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            obj_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (frame_start) begin
                obj_q <= obj_d;
            end
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Blink uses the post-increment counter so a frame start and a perdeu
    // change in the same cycle pick the new phase.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            act_s1   <= 1'b0;
            nave_s1  <= 1'b0;
            ini_s1   <= 1'b0;
            blink_s1 <= 1'b0;
            act_s2   <= 1'b0;
            nave_s2  <= 1'b0;
            ini_s2   <= 1'b0;
            blink_s2 <= 1'b0;
        end else begin
            act_s1   <= ativoVGA;
            nave_s1  <= rect_hit(xs, ys, obj_q.nave_x, obj_q.nave_y, obj_q.nave_w, obj_q.nave_h);
            ini_s1   <= rect_hit(xs, ys, obj_q.ini_x, obj_q.ini_y, obj_q.ini_w, obj_q.ini_h);
            blink_s1 <= perdeu && frame_cnt_d[BLINK_BIT];
            act_s2   <= act_s1;
            nave_s2  <= nave_s1;
            ini_s2   <= ini_s1;
            blink_s2 <= blink_s1;
        end
    end

`ifdef PINTOR_BORDA_EN
    logic borda_s1, borda_s2;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            borda_s1 <= 1'b0;
            borda_s2 <= 1'b0;
        end else begin
            borda_s1 <= is_borda(xs, ys);
            borda_s2 <= borda_s1;
        end
    end
`endif

    circulo_hit u_bola_nave (
        .clk (CLOCK_50),
        .rst (reset),
        .xs  (xs),
        .ys  (ys),
        .cx  (obj_q.bn_x),
        .cy  (obj_q.bn_y),
        .r   (obj_q.bn_r),
        .hit (bn_hit)
    );

    circulo_hit u_bola_inimigo (
        .clk (CLOCK_50),
        .rst (reset),
        .xs  (xs),
        .ys  (ys),
        .cx  (obj_q.bi_x),
        .cy  (obj_q.bi_y),
        .r   (obj_q.bi_r),
        .hit (bi_hit)
    );

    // Stage 3: priority mux
    always_comb begin
        prio = PrioFundo;
        if (bn_hit) begin
            prio = PrioBolaNave;
        end else if (bi_hit) begin
            prio = PrioBolaInimigo;
        end else if (nave_s2) begin
            prio = PrioNave;
        end else if (ini_s2) begin
            prio = PrioInimigo;
`ifdef PINTOR_BORDA_EN
        end else if (borda_s2) begin
            prio = PrioBorda;
`endif
        end
        rgb_d = act_s2 ? prio_color(prio, blink_s2) : COR_PRETO;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rgb_q   <= COR_PRETO;
            ativo_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            ativo_q <= act_s2;
        end
    end

    assign R_AUX     = rgb_q.r;
    assign G_AUX     = rgb_q.g;
    assign B_AUX     = rgb_q.b;
    assign ativo_out = ativo_q;

endmodule

// File: tb/tb_pintor_pixel.sv
module tb_pintor_pixel;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] xVGA = 10'd1, yVGA = 10'd1;
    logic       ativoVGA = 1'b0, perdeu = 1'b0;
    logic [9:0] BordaNaveX = '0, BordaNaveY = '0, LarguraNave = '0, AlturaNave = '0;
    logic [9:0] BordaInimigoX = '0, BordaInimigoY = '0, LarguraInimigo = '0, AlturaInimigo = '0;
    logic [9:0] BolaNaveX = '0, BolaNaveY = '0, RaioBolaNave = '0;
    logic [9:0] BolaInimigoX = '0, BolaInimigoY = '0, RaioBolaInimigo = '0;
    logic [2:0] R_AUX, G_AUX, B_AUX;
    logic       ativo_out;

    always #5 clk = ~clk;

    pintor_pixel dut (
        .CLOCK_50        (clk),
        .reset           (rst),
        .xVGA            (xVGA),
        .yVGA            (yVGA),
        .ativoVGA        (ativoVGA),
        .perdeu          (perdeu),
        .BordaNaveX      (BordaNaveX),
        .BordaNaveY      (BordaNaveY),
        .LarguraNave     (LarguraNave),
        .AlturaNave      (AlturaNave),
        .BordaInimigoX   (BordaInimigoX),
        .BordaInimigoY   (BordaInimigoY),
        .LarguraInimigo  (LarguraInimigo),
        .AlturaInimigo   (AlturaInimigo),
        .BolaNaveX       (BolaNaveX),
        .BolaNaveY       (BolaNaveY),
        .RaioBolaNave    (RaioBolaNave),
        .BolaInimigoX    (BolaInimigoX),
        .BolaInimigoY    (BolaInimigoY),
        .RaioBolaInimigo (RaioBolaInimigo),
        .R_AUX           (R_AUX),
        .G_AUX           (G_AUX),
        .B_AUX           (B_AUX),
        .ativo_out       (ativo_out)
    );

`ifdef PINTOR_BORDA_EN
    localparam logic [8:0] BORDA_EXP = 9'o333;
`else
    localparam logic [8:0] BORDA_EXP = 9'o000;
`endif

    typedef struct {
        logic [8:0] rgb;
        logic       act;
        bit         has_lit;
        logic [8:0] lit;
        int         id;
    } exp_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t cur_exp;
    exp_t pipe[3];

    // Model state: shadow copies and frame count, as the screen sees them.
    int s_nx, s_ny, s_nw, s_nh, s_ix, s_iy, s_iw, s_ih;
    int s_bnx, s_bny, s_bnr, s_bix, s_biy, s_bir;
    int m_cnt;

    function automatic bit in_circle(int xs, int ys, int cx, int cy, int r);
        return (r > 0) && ((xs - cx) * (xs - cx) + (ys - cy) * (ys - cy) <= r * r);
    endfunction

    function automatic bit in_rect(int xs, int ys, int x, int y, int w, int h);
        return (xs >= x) && (xs < x + w) && (ys >= y) && (ys < y + h);
    endfunction

    function automatic logic [8:0] model_rgb(int x, int y, bit act);
        int xs, ys;
        xs = x - 144;
        ys = y - 35;
        if (!act) return 9'o000;
        if (in_circle(xs, ys, s_bnx, s_bny, s_bnr)) return 9'o777;
        if (in_circle(xs, ys, s_bix, s_biy, s_bir)) return 9'o770;
        if (in_rect(xs, ys, s_nx, s_ny, s_nw, s_nh)) return 9'o070;
        if (in_rect(xs, ys, s_ix, s_iy, s_iw, s_ih)) return 9'o700;
`ifdef PINTOR_BORDA_EN
        if (xs == 0 || xs == 639 || ys == 0 || ys == 479) return 9'o333;
`endif
        if (perdeu && m_cnt >= 32) return 9'o400;
        return 9'o000;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.rgb = 9'o000; e.act = 1'b0; e.has_lit = 1'b0; e.lit = 9'o000; e.id = 0;
        return e;
    endfunction

    task automatic latch_model();
        s_nx = BordaNaveX;      s_ny = BordaNaveY;      s_nw = LarguraNave;    s_nh = AlturaNave;
        s_ix = BordaInimigoX;   s_iy = BordaInimigoY;   s_iw = LarguraInimigo; s_ih = AlturaInimigo;
        s_bnx = BolaNaveX;      s_bny = BolaNaveY;      s_bnr = RaioBolaNave;
        s_bix = BolaInimigoX;   s_biy = BolaInimigoY;   s_bir = RaioBolaInimigo;
    endtask

    task automatic clear_model();
        s_nx = 0; s_ny = 0; s_nw = 0; s_nh = 0; s_ix = 0; s_iy = 0; s_iw = 0; s_ih = 0;
        s_bnx = 0; s_bny = 0; s_bnr = 0; s_bix = 0; s_biy = 0; s_bir = 0;
        m_cnt = 0;
    endtask

    task automatic drive(input int x, input int y, input bit act, input bit chk,
                         input logic [8:0] lit, input int id);
        exp_t e;
        @(posedge clk);
        #1;
        xVGA = 10'(x);
        yVGA = 10'(y);
        ativoVGA = act;
        if (x == 0 && y == 0) m_cnt = (m_cnt + 1) % 64;
        e.rgb = model_rgb(x, y, act);
        e.act = act;
        e.has_lit = chk;
        e.lit = lit;
        e.id = id;
        if (x == 0 && y == 0) latch_model();
        cur_exp = e;
    endtask

    // Visible pixel by screen coordinate, with a hand-computed expectation.
    task automatic spix(input int xs, input int ys, input logic [8:0] lit, input int id);
        drive(xs + 144, ys + 35, 1'b1, 1'b1, lit, id);
    endtask

    task automatic frame();
        drive(0, 0, 1'b0, 1'b0, 9'o000, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 1'b0, 1'b0, 9'o000, 0);
    endtask

    task automatic set_objs(input int nx, ny, nw, nh, ix, iy, iw, ih,
                            input int bnx, bny, bnr, bix, biy, bir);
        BordaNaveX = 10'(nx);    BordaNaveY = 10'(ny);    LarguraNave = 10'(nw);
        AlturaNave = 10'(nh);    BordaInimigoX = 10'(ix); BordaInimigoY = 10'(iy);
        LarguraInimigo = 10'(iw); AlturaInimigo = 10'(ih);
        BolaNaveX = 10'(bnx);    BolaNaveY = 10'(bny);    RaioBolaNave = 10'(bnr);
        BolaInimigoX = 10'(bix); BolaInimigoY = 10'(biy); RaioBolaInimigo = 10'(bir);
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        xVGA = 10'd1;
        yVGA = 10'd1;
        ativoVGA = 1'b0;
        clear_model();
        cur_exp = zero_exp();
    endtask

    task automatic leave_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Compare process: output seen at this negedge belongs to the input driven three drives ago.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                n_vec++;
                if ({R_AUX, G_AUX, B_AUX} != 9'o000 || ativo_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL in_reset: rgb=%o ativo_out=%b required rgb=000 ativo_out=0",
                             {R_AUX, G_AUX, B_AUX}, ativo_out);
                end
                for (int i = 0; i < 3; i++) pipe[i] = zero_exp();
            end else begin
                n_vec++;
                if ({R_AUX, G_AUX, B_AUX} !== pipe[2].rgb || ativo_out !== pipe[2].act) begin
                    n_bad++;
                    $display("FAIL model id=%0d t=%0t: rgb=%o ativo_out=%b required rgb=%o ativo_out=%b",
                             pipe[2].id, $time, {R_AUX, G_AUX, B_AUX}, ativo_out,
                             pipe[2].rgb, pipe[2].act);
                end
                if (pipe[2].has_lit) begin
                    n_vec++;
                    if ({R_AUX, G_AUX, B_AUX} !== pipe[2].lit) begin
                        n_bad++;
                        $display("FAIL literal id=%0d: rgb=%o required %o",
                                 pipe[2].id, {R_AUX, G_AUX, B_AUX}, pipe[2].lit);
                    end
                end
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = cur_exp;
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = zero_exp();
        cur_exp = zero_exp();
        clear_model();
        #1;
        enter_reset();
        leave_reset();
        idle(4);

        // Ship projectile: not visible until latched at frame start
        set_objs(0, 0, 0, 0, 0, 0, 0, 0, 320, 240, 10, 0, 0, 0);
        spix(320, 240, 9'o000, 1);
        frame();
        spix(320, 240, 9'o777, 2);
        spix(330, 240, 9'o777, 3);
        spix(328, 247, 9'o000, 4);

        // Priority and both rectangles
        set_objs(300, 230, 50, 20, 500, 100, 30, 30, 320, 240, 10, 600, 400, 5);
        frame();
        spix(320, 240, 9'o777, 10);
        spix(345, 245, 9'o070, 11);
        spix(510, 110, 9'o700, 12);
        spix(600, 400, 9'o770, 13);
        spix(605, 400, 9'o770, 14);
        spix(606, 400, 9'o000, 15);
        spix(349, 249, 9'o070, 16);
        spix(350, 249, 9'o000, 17);
        spix(300, 230, 9'o070, 18);
        drive(320 + 144, 240 + 35, 1'b0, 1'b1, 9'o000, 19);

        // Latch point: mid-frame change is invisible until next frame start
        BolaNaveX = 10'd100;
        spix(320, 240, 9'o777, 20);
        spix(100, 240, 9'o000, 21);
        frame();
        spix(100, 240, 9'o777, 22);
        spix(320, 240, 9'o070, 23);

        // Radius 0 draws nothing, even at its own centre
        BolaInimigoX = 10'd50;
        BolaInimigoY = 10'd50;
        RaioBolaInimigo = 10'd0;
        frame();
        spix(50, 50, 9'o000, 30);

        // Border pixels
        spix(0, 100, BORDA_EXP, 31);
        spix(639, 100, BORDA_EXP, 32);
        spix(1, 100, 9'o000, 33);

        // Reset mid-frame while white is on the output
        repeat (4) spix(100, 240, 9'o777, 40);
        @(posedge clk);
        #2;
        n_vec++;
        if ({R_AUX, G_AUX, B_AUX} !== 9'o777) begin
            n_bad++;
            $display("FAIL pre_reset_white: rgb=%o required 777", {R_AUX, G_AUX, B_AUX});
        end
        enter_reset();
        #1;
        n_vec++;
        if ({R_AUX, G_AUX, B_AUX} !== 9'o000 || ativo_out !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: rgb=%o ativo_out=%b required rgb=000 ativo_out=0",
                     {R_AUX, G_AUX, B_AUX}, ativo_out);
        end
        leave_reset();
        spix(100, 240, 9'o000, 41);

        // Game-over blink across 64 frame starts, counter starting at 0
        perdeu = 1'b1;
        spix(56, 165, 9'o000, 50);
        for (int k = 1; k <= 64; k++) begin
            frame();
            spix(56, 165, ((k % 64) >= 32) ? 9'o400 : 9'o000, 100 + k);
            if (k == 40) spix(100, 240, 9'o777, 51);
        end
        perdeu = 1'b0;
        spix(56, 165, 9'o000, 52);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
